branch_resolve_unit: RTL and testbench

- Parametrised successor to the combinational branch comparator.
- Resolves RV32/RV64 conditional branches in EX and compares the outcome with the fetch-stage prediction.
- Registers a taken / mispredict / redirect result for the fetch stage.
- Owns a BHT of 2-bit saturating counters: fetch reads it combinationally; resolved branches update it.

---
 rtl/branch_resolve_unit.sv | 91 +++++++++
 tb/tb_branch_resolve_unit.sv | 176 +++++++++++++++++
 2 files changed

// File: rtl/branch_resolve_unit.sv
// rtl/branch_resolve_unit.sv - EX-stage branch resolver with 2-bit BHT; optional BRU_PERF_CNT_EN adds perf counters
module branch_resolve_unit #(
  parameter  int XLEN      = 32,
  parameter  int BHT_DEPTH = 64,
  localparam int BHT_IDX_W = $clog2(BHT_DEPTH)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [XLEN-1:0] f_pc,
  output logic            f_pred_taken,
  input  logic            ex_valid,
  input  logic            ex_flush,
  input  logic            br_type,
  input  logic [2:0]      funct3,
  input  logic [XLEN-1:0] rs1_data,
  input  logic [XLEN-1:0] rs2_data,
  input  logic [XLEN-1:0] ex_pc,
  input  logic [XLEN-1:0] ex_target,
  input  logic            ex_pred_taken,
  output logic            take_branch,
  output logic            mispredict,
  output logic [XLEN-1:0] redirect_pc
`ifdef BRU_PERF_CNT_EN
  ,
  output logic [31:0]     perf_br_cnt,
  output logic [31:0]     perf_mispred_cnt
`endif
);

  logic [1:0]           bht [BHT_DEPTH];
  logic [BHT_IDX_W-1:0] f_idx;
  logic [BHT_IDX_W-1:0] ex_idx;
  logic                 res_en;
  logic                 legal;
  logic                 cond;
  logic                 mis_next;
  logic                 unused_pc_bits;

  assign f_idx        = f_pc[BHT_IDX_W+1:2];
  assign ex_idx       = ex_pc[BHT_IDX_W+1:2];
  assign f_pred_taken = bht[f_idx][1];
  assign res_en       = ex_valid & br_type & ~ex_flush;
  assign mis_next     = res_en & (cond != ex_pred_taken);

  assign unused_pc_bits = ^{f_pc[1:0], f_pc[XLEN-1:BHT_IDX_W+2]};

  always_comb begin
    legal = 1'b1;
    cond  = 1'b0;
    case (funct3)
      3'b000:  cond = (rs1_data == rs2_data);
      3'b001:  cond = (rs1_data != rs2_data);
      3'b100:  cond = ($signed(rs1_data) <  $signed(rs2_data));
      3'b101:  cond = ($signed(rs1_data) >= $signed(rs2_data));
      3'b110:  cond = (rs1_data <  rs2_data);
      3'b111:  cond = (rs1_data >= rs2_data);
      default: legal = 1'b0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < BHT_DEPTH; i++) bht[i] <= 2'b01;
      take_branch <= 1'b0;
      mispredict  <= 1'b0;
      redirect_pc <= '0;
    end else begin
      take_branch <= res_en & cond;
      mispredict  <= mis_next;
      if (res_en) redirect_pc <= cond ? ex_target : ex_pc + XLEN'(4);
      // Illegal funct3 resolves not-taken but must not train the predictor.
      if (res_en && legal) begin
        if (cond && bht[ex_idx] != 2'b11)       bht[ex_idx] <= bht[ex_idx] + 2'b01;
        else if (!cond && bht[ex_idx] != 2'b00) bht[ex_idx] <= bht[ex_idx] - 2'b01;
      end
    end
  end

`ifdef BRU_PERF_CNT_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      perf_br_cnt      <= '0;
      perf_mispred_cnt <= '0;
    end else begin
      if (res_en)   perf_br_cnt      <= perf_br_cnt + 32'd1;
      if (mis_next) perf_mispred_cnt <= perf_mispred_cnt + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_branch_resolve_unit.sv
// tb/tb_branch_resolve_unit.sv - table-driven scoreboard bench for branch_resolve_unit
module tb_branch_resolve_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] f_pc;
  logic        f_pred_taken;
  logic        ex_valid, ex_flush, br_type, ex_pred_taken;
  logic [2:0]  funct3;
  logic [31:0] rs1_data, rs2_data, ex_pc, ex_target;
  logic        take_branch, mispredict;
  logic [31:0] redirect_pc;
`ifdef BRU_PERF_CNT_EN
  logic [31:0] perf_br_cnt, perf_mispred_cnt;
  int unsigned exp_br_cnt = 0, exp_mis_cnt = 0;
`endif

  branch_resolve_unit #(.XLEN(32), .BHT_DEPTH(64)) dut (
    .clk(clk), .rst(rst), .f_pc(f_pc), .f_pred_taken(f_pred_taken),
    .ex_valid(ex_valid), .ex_flush(ex_flush), .br_type(br_type), .funct3(funct3),
    .rs1_data(rs1_data), .rs2_data(rs2_data), .ex_pc(ex_pc), .ex_target(ex_target),
    .ex_pred_taken(ex_pred_taken), .take_branch(take_branch), .mispredict(mispredict),
    .redirect_pc(redirect_pc)
`ifdef BRU_PERF_CNT_EN
    , .perf_br_cnt(perf_br_cnt), .perf_mispred_cnt(perf_mispred_cnt)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        v, fl, br;
    logic [2:0]  f3;
    logic [31:0] rs1, rs2, pc, tgt;
    logic        pred;
    logic        e_take, e_mis;
    logic [31:0] e_redir;
    logic        e_fpred;
  } vec_t;

  typedef struct {
    logic        take, mis;
    logic [31:0] redir;
    logic        fpred;
  } exp_t;

  vec_t vecs[18];
  exp_t sb[$];
  int   n_tests = 0, n_fail = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic idle();
    ex_valid = 0; ex_flush = 0; br_type = 0; funct3 = 3'b000; ex_pred_taken = 0;
    rs1_data = 0; rs2_data = 0; ex_pc = 0; ex_target = 0;
  endtask

  // Called just after a negedge: drive one vector, then score the outputs one cycle later.
  task automatic apply(input vec_t t, input string name);
    exp_t e;
    ex_valid = t.v; ex_flush = t.fl; br_type = t.br; funct3 = t.f3;
    rs1_data = t.rs1; rs2_data = t.rs2; ex_pc = t.pc; ex_target = t.tgt;
    ex_pred_taken = t.pred; f_pc = t.pc;
    e.take = t.e_take; e.mis = t.e_mis; e.redir = t.e_redir; e.fpred = t.e_fpred;
    sb.push_back(e);
`ifdef BRU_PERF_CNT_EN
    if (t.v && t.br && !t.fl) exp_br_cnt++;
    if (t.v && t.br && !t.fl && t.e_mis) exp_mis_cnt++;
`endif
    @(negedge clk);
    idle();
    if (sb.size() == 0) begin
      check({name, "_sb_empty"}, 32'd1, 32'd0);
    end else begin
      e = sb.pop_front();
      check({name, "_take"},  {31'd0, take_branch},  {31'd0, e.take});
      check({name, "_mis"},   {31'd0, mispredict},   {31'd0, e.mis});
      check({name, "_redir"}, redirect_pc,           e.redir);
      check({name, "_fpred"}, {31'd0, f_pred_taken}, {31'd0, e.fpred});
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    // v fl br f3 rs1 rs2 pc tgt pred | take mis redir fpred
    vecs[0]  = '{1,0,1,3'b000,32'd5,32'd5,32'h100,32'h140,0, 1,1,32'h140,1};
    vecs[1]  = '{1,0,1,3'b100,32'hFFFFFFFF,32'd1,32'h180,32'h1C0,0, 1,1,32'h1C0,1};
    vecs[2]  = '{1,0,1,3'b110,32'hFFFFFFFF,32'd1,32'h200,32'h240,1, 0,1,32'h204,0};
    vecs[3]  = '{1,0,1,3'b001,32'd1,32'd2,32'h300,32'h380,0, 1,1,32'h380,1};
    vecs[4]  = '{1,0,1,3'b001,32'd1,32'd2,32'h300,32'h380,1, 1,0,32'h380,1};
    vecs[5]  = '{1,0,1,3'b001,32'd1,32'd2,32'h300,32'h380,1, 1,0,32'h380,1};
    vecs[6]  = '{1,0,1,3'b001,32'd1,32'd2,32'h300,32'h380,1, 1,0,32'h380,1};
    vecs[7]  = '{1,0,1,3'b001,32'd7,32'd7,32'h300,32'h380,1, 0,1,32'h304,1};
    vecs[8]  = '{1,1,1,3'b000,32'd3,32'd3,32'h300,32'h380,0, 0,0,32'h304,1};
    vecs[9]  = '{1,0,1,3'b010,32'd1,32'd1,32'hFFFFFFFC,32'h40,1, 0,1,32'h0,0};
    vecs[10] = '{1,0,1,3'b011,32'd1,32'd1,32'h10,32'h50,0, 0,0,32'h14,0};
    vecs[11] = '{0,0,1,3'b000,32'd1,32'd1,32'h10,32'h50,0, 0,0,32'h14,0};
    vecs[12] = '{1,0,0,3'b000,32'd1,32'd1,32'h10,32'h50,1, 0,0,32'h14,0};
    vecs[13] = '{1,0,1,3'b101,32'd1,32'hFFFFFFFF,32'h20,32'h60,1, 1,0,32'h60,1};
    vecs[14] = '{1,0,1,3'b111,32'd1,32'hFFFFFFFF,32'h20,32'h60,1, 0,1,32'h24,0};
    vecs[15] = '{1,0,1,3'b000,32'h80000000,32'd0,32'h24,32'h64,0, 0,0,32'h28,0};
    vecs[16] = '{1,0,1,3'b100,32'd5,32'd5,32'h24,32'h64,0, 0,0,32'h28,0};
    vecs[17] = '{1,0,1,3'b100,32'hFFFFFFFE,32'hFFFFFFFF,32'h28,32'h0,1, 1,0,32'h0,1};

    idle();
    f_pc = 32'h100;
    rst = 1;
    repeat (2) @(negedge clk);
    rst = 0;
    #1;
    check("rst_take",  {31'd0, take_branch},  32'd0);
    check("rst_mis",   {31'd0, mispredict},   32'd0);
    check("rst_redir", redirect_pc,           32'd0);
    check("rst_fpred", {31'd0, f_pred_taken}, 32'd0);
    @(negedge clk);

    for (int i = 0; i < 18; i++) apply(vecs[i], $sformatf("vec%0d", i));

`ifdef BRU_PERF_CNT_EN
    check("perf_br",  perf_br_cnt,      exp_br_cnt);
    check("perf_mis", perf_mispred_cnt, exp_mis_cnt);
`endif

    // Read/write collision on index 32 (counter is 10): old value until the edge.
    f_pc = 32'h180; ex_valid = 1; br_type = 1; funct3 = 3'b000;
    rs1_data = 1; rs2_data = 2; ex_pc = 32'h180; ex_target = 32'h1C0; ex_pred_taken = 1;
    #1;
    check("coll_old", {31'd0, f_pred_taken}, 32'd1);
    @(negedge clk);
    idle();
    check("coll_new", {31'd0, f_pred_taken}, 32'd0);
    check("coll_mis", {31'd0, mispredict},   32'd1);
    check("coll_red", redirect_pc,           32'h184);

    // Reset in the same cycle as a mispredicting taken branch.
    ex_valid = 1; br_type = 1; funct3 = 3'b000; rs1_data = 9; rs2_data = 9;
    ex_pc = 32'h100; ex_target = 32'h500; ex_pred_taken = 0; rst = 1;
    @(negedge clk);
    idle();
    rst = 0;
    check("rr_take",  {31'd0, take_branch}, 32'd0);
    check("rr_mis",   {31'd0, mispredict},  32'd0);
    check("rr_redir", redirect_pc,          32'd0);
`ifdef BRU_PERF_CNT_EN
    check("rr_perf_br",  perf_br_cnt,      32'd0);
    check("rr_perf_mis", perf_mispred_cnt, 32'd0);
`endif
    @(negedge clk);
    check("post_rst_take", {31'd0, take_branch}, 32'd0);
    check("post_rst_mis",  {31'd0, mispredict},  32'd0);
    for (int i = 0; i < 64; i++) begin
      f_pc = 32'(i) << 2;
      #1;
      check($sformatf("rst_bht%0d", i), {31'd0, f_pred_taken}, 32'd0);
    end
    // A single taken update from 01 must flip the prediction; from 00 it would not.
    apply('{1,0,1,3'b000,32'd4,32'd4,32'h100,32'h140,1, 1,0,32'h140,1}, "rst_is_01");
    apply('{1,0,1,3'b100,32'hFFFFFFFE,32'hFFFFFFFF,32'h1C0,32'h10,0, 1,1,32'h10,1}, "rst_is_01b");

    if (sb.size() != 0) check("sb_drained", sb.size(), 32'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
